// File: rtl/cv_clock_pkg.sv
// Shared widths, reset rate and types for the 10.7 MHz clock-enable generator.
package cv_clock_pkg;

    localparam int unsigned CV_ACC_W        = 32;
    localparam int unsigned CV_INC_NTSC_50M = 922441727;
    localparam int unsigned CV_DEBT_W       = 8;

    typedef logic [CV_ACC_W-1:0]  cv_acc_t;
    typedef logic [CV_DEBT_W-1:0] cv_debt_t;

endpackage

// File: rtl/cv_clk_nco.sv
// Phase accumulator with a clamped, runtime-loadable increment; carry marks one enable.
module cv_clk_nco
    import cv_clock_pkg::*;
#(
    parameter int unsigned       ACC_W   = CV_ACC_W,
    parameter logic [ACC_W-1:0]  INC_RST = ACC_W'(CV_INC_NTSC_50M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_we,
    input  logic [ACC_W-1:0] inc,
    output logic             carry_c
);

    // Below half scale two consecutive carries are impossible.
    localparam logic [ACC_W-1:0] INC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W:0]   sum;

    assign sum     = {1'b0, acc} + {1'b0, inc_q};
    assign carry_c = sum[ACC_W];

    // Accumulator keeps running through holds and rate loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            inc_q <= INC_RST;
        end else begin
            acc <= sum[ACC_W-1:0];
            if (inc_we) begin
                inc_q <= (inc > INC_MAX) ? INC_MAX : inc;
            end
        end
    end

endmodule

// File: rtl/cv_clk_en_gen.sv
// 10.7 MHz clock-enable NCO with hold; CV_CLK_EN_CATCHUP_EN enables repayment of
// enables missed during a hold through a saturating debt counter.
module cv_clk_en_gen
    import cv_clock_pkg::*;
#(
    parameter int unsigned       ACC_W   = CV_ACC_W,
    parameter logic [ACC_W-1:0]  INC_RST = ACC_W'(CV_INC_NTSC_50M),
    parameter int unsigned       DEBT_W  = CV_DEBT_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              hold_i,
    input  logic              inc_we_i,
    input  logic [ACC_W-1:0]  inc_i,
    output logic              clk_en_10m7_o,
    output logic [DEBT_W-1:0] debt_o,
    output logic              debt_ovf_o
);

    logic carry_c;
    logic emit_c;

    cv_clk_nco #(
        .ACC_W   (ACC_W),
        .INC_RST (INC_RST)
    ) u_nco (
        .clk     (clk_i),
        .reset   (reset_i),
        .inc_we  (inc_we_i),
        .inc     (inc_i),
        .carry_c (carry_c)
    );

`ifdef CV_CLK_EN_CATCHUP_EN
    localparam logic [DEBT_W-1:0] DEBT_MAX = '1;

    logic [DEBT_W-1:0] debt_q;
    logic [DEBT_W-1:0] debt_next_c;
    logic              ovf_q;
    logic              pending_c;
    logic              sat_c;

    // Carry and emit together pay the oldest enable, leaving debt unchanged.
    always_comb begin
        pending_c   = carry_c | (debt_q != '0);
        emit_c      = pending_c & ~hold_i & ~clk_en_10m7_o;
        sat_c       = (debt_q == DEBT_MAX) & carry_c & ~emit_c;
        debt_next_c = debt_q;
        if (!sat_c) begin
            if (carry_c && !emit_c) begin
                debt_next_c = debt_q + DEBT_W'(1);
            end else if (!carry_c && emit_c) begin
                debt_next_c = debt_q - DEBT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            debt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            debt_q <= debt_next_c;
            if (sat_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign debt_o     = debt_q;
    assign debt_ovf_o = ovf_q;
`else
    // Carries arriving during a hold are simply dropped.
    assign emit_c     = carry_c & ~hold_i & ~clk_en_10m7_o;
    assign debt_o     = '0;
    assign debt_ovf_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_en_10m7_o <= 1'b0;
        end else begin
            clk_en_10m7_o <= emit_c;
        end
    end

endmodule
